// File: rtl/uart_periph.sv
// uart_periph: byte-wide UART peripheral for the Z80 I/O bank 0x00.
//
// CPU writes to the data register (addr_i=0) are serialised as 8N1 frames
// on tx_o. Frames arriving on rx_i are assembled into bytes that the CPU
// reads back from the same register. addr_i=1 reads the status byte:
//   bit0 rx_avail, bit1 tx_ready, bit2 tx_busy, bit3 overrun, bit4 frame_err
//
// Ports:
//   clk_i    system clock, all flops on its rising edge
//   rst_n_i  asynchronous active-low reset
//   cs_i     chip select from the address decoder (active-high)
//   wr_n     CPU write strobe (active-low)
//   rd_n     CPU read strobe (active-low)
//   addr_i   register select: 0 = data, 1 = status
//   data_i   CPU write data
//   data_o   CPU read data (combinational, 0x00 outside a read access)
//   tx_o     serial transmit line, idles high
//   rx_i     serial receive line, asynchronous to clk_i
//
// Build option: define UART_RX_FIFO_EN for an 8-entry RX FIFO; otherwise
// the RX side stores a single byte.
module uart_periph #(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cs_i,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       tx_o,
  input  logic       rx_i
);

  localparam int          DIV       = CLK_HZ / BAUD;
  localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(DIV / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // CPU bus strobes
  logic wr_acc, wr_acc_q, wr_edge;
  logic rd_acc, rd_acc_q, rd_addr_q, rd_end;

  assign wr_acc  = cs_i & ~wr_n;
  assign wr_edge = wr_acc & ~wr_acc_q;
  assign rd_acc  = cs_i & ~rd_n;
  // Side effects of a read happen once the access has finished, using the
  // register address latched while the access was live.
  assign rd_end  = rd_acc_q & ~rd_acc;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_acc_q  <= 1'b0;
      rd_acc_q  <= 1'b0;
      rd_addr_q <= 1'b0;
    end else begin
      wr_acc_q <= wr_acc;
      rd_acc_q <= rd_acc;
      if (rd_acc) rd_addr_q <= addr_i;
    end
  end

  // Transmit path
  logic [7:0]  hold;
  logic        hold_full;
  logic [1:0]  tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_cnt_done, tx_take, tx_busy;

  assign tx_cnt_done = (tx_cnt == DIV_LAST);
  // The shifter takes a waiting byte when idle, or on the last stop-bit
  // clock so that consecutive frames follow with no idle gap.
  assign tx_take = hold_full &
                   ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_cnt_done));
  assign tx_busy = (tx_state != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold      <= 8'h00;
      hold_full <= 1'b0;
    end else if (tx_take) begin
      hold_full <= 1'b0;
    end else if (wr_edge & ~addr_i & ~hold_full) begin
      hold      <= data_i;
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      tx_o     <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_take) begin
            tx_shift <= hold;
            tx_cnt   <= 16'd0;
            tx_state <= S_START;
            tx_o     <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt_done) begin
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_state <= S_DATA;
            tx_o     <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt_done) begin
            tx_cnt <= 16'd0;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              tx_o     <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_o     <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: begin
          if (tx_cnt_done) begin
            tx_cnt <= 16'd0;
            if (tx_take) begin
              tx_shift <= hold;
              tx_state <= S_START;
              tx_o     <= 1'b0;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Receive path
  logic        rx_s1, rx_s2, rx_prev;
  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_cnt_done, rx_stop_hit;

  assign rx_cnt_done = (rx_cnt == DIV_LAST);
  // Single-cycle pulse at the mid-point of the stop bit.
  assign rx_stop_hit = (rx_state == S_STOP) & rx_cnt_done;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev & ~rx_s2) begin
            rx_cnt   <= 16'd0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          // Half a bit in: still low means a real start bit, and every later
          // sample lands mid-bit.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt_done) begin
            rx_cnt   <= 16'd0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: begin
          if (rx_cnt_done) begin
            rx_cnt   <= 16'd0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // RX storage
  logic       rx_avail, rx_full, rx_store, rx_pop;
  logic [7:0] rx_head;

  assign rx_store = rx_stop_hit & ~rx_full;
  assign rx_pop   = rd_end & ~rd_addr_q & rx_avail;

`ifdef UART_RX_FIFO_EN
  logic [7:0] rx_mem [0:7];
  logic [2:0] rx_wptr, rx_rptr;
  logic [3:0] rx_count;

  assign rx_avail = (rx_count != 4'd0);
  assign rx_full  = (rx_count == 4'd8);
  assign rx_head  = rx_mem[rx_rptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_wptr  <= 3'd0;
      rx_rptr  <= 3'd0;
      rx_count <= 4'd0;
    end else begin
      if (rx_store) rx_wptr <= rx_wptr + 3'd1;
      if (rx_pop)   rx_rptr <= rx_rptr + 3'd1;
      case ({rx_store, rx_pop})
        2'b10:   rx_count <= rx_count + 4'd1;
        2'b01:   rx_count <= rx_count - 4'd1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_store) rx_mem[rx_wptr] <= rx_shift;
  end
`else
  logic [7:0] rx_data;
  logic       rx_valid;

  assign rx_avail = rx_valid;
  assign rx_full  = rx_valid;
  assign rx_head  = rx_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (rx_store) begin
      rx_data  <= rx_shift;
      rx_valid <= 1'b1;
    end else if (rx_pop) begin
      rx_valid <= 1'b0;
    end
  end
`endif

  // Error flags: a status read clears them, but a flag raised in the clearing
  // cycle wins.
  logic overrun, frame_err, flag_clr;

  assign flag_clr = rd_end & rd_addr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (overrun & ~flag_clr) | (rx_stop_hit & rx_full);
      frame_err <= (frame_err & ~flag_clr) | (rx_stop_hit & ~rx_s2);
    end
  end

  // CPU read mux
  logic [7:0] status;

  assign status = {3'b000, frame_err, overrun, tx_busy, ~hold_full, rx_avail};

  always_comb begin
    data_o = 8'h00;
    if (rd_acc) begin
      if (addr_i)        data_o = status;
      else if (rx_avail) data_o = rx_head;
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
module tb_uart_periph;
  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int D      = CLK_HZ / BAUD;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       cs_i = 1'b0;
  logic       wr_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       addr_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       tx_o;
  logic       rx_i = 1'b1;

  uart_periph #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .cs_i(cs_i), .wr_n(wr_n), .rd_n(rd_n),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .tx_o(tx_o), .rx_i(rx_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // Scoreboard queues
  typedef struct { logic [7:0] b; int start; } txe_t;
  txe_t       tx_exp[$];
  bit         tx_abort = 1'b0;
  logic [7:0] rd_exp[$];
  string      rd_name[$];

  // Reference model
  logic [7:0] m_rx[$];
  bit         m_ov = 1'b0;
  bit         m_fe = 1'b0;
  int         m_starts[$];
  int         m_wr[$];
  int         m_take[$];
  int         last_take = -1;
  int         last_start = -100000;

  function automatic bit m_busy(int c);
    foreach (m_starts[i])
      if (m_starts[i] <= c && c < m_starts[i] + 10 * D) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready(int c);
    foreach (m_wr[i])
      if (m_wr[i] < c && c <= m_take[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] m_status(int c);
    return {3'b000, m_fe, m_ov, m_busy(c), m_ready(c), (m_rx.size() != 0)};
  endfunction

  task automatic model_reset();
    m_rx.delete(); m_starts.delete(); m_wr.delete(); m_take.delete();
    m_ov = 1'b0; m_fe = 1'b0;
    last_take = -1; last_start = -100000;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d, input int hold_cycles);
    int w, lim, take;
    w = cyc;
    if (!a && w > last_take) begin
      lim  = last_start + 10 * D - 1;
      take = (w + 1 > lim) ? w + 1 : lim;
      m_wr.push_back(w);
      m_take.push_back(take);
      m_starts.push_back(take + 1);
      tx_exp.push_back('{b: d, start: take + 1});
      last_take  = take;
      last_start = take + 1;
    end
    cs_i = 1'b1; wr_n = 1'b0; addr_i = a; data_i = d;
    idle(hold_cycles);
    cs_i = 1'b0; wr_n = 1'b1;
  endtask

  task automatic cpu_read(input logic a, input int n, input string name);
    int c;
    c = cyc;
    for (int k = 0; k < n; k++) begin
      rd_exp.push_back(a ? m_status(c + k) : ((m_rx.size() != 0) ? m_rx[0] : 8'h00));
      rd_name.push_back(name);
    end
    if (a) begin
      m_ov = 1'b0; m_fe = 1'b0;
    end else if (m_rx.size() != 0) begin
      void'(m_rx.pop_front());
    end
    cs_i = 1'b1; rd_n = 1'b0; addr_i = a;
    idle(n);
    cs_i = 1'b0; rd_n = 1'b1;
    idle(1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = bits[i];
      repeat (D) @(posedge clk);
      #1;
    end
    rx_i = 1'b1;
    idle(4);
    if (!stop) m_fe = 1'b1;
    if (m_rx.size() < CAP) m_rx.push_back(b);
    else m_ov = 1'b1;
  endtask

  // Read-side monitor: every cycle with a read access consumes one expected
  // value; outside an access data_o must read as zero.
  always @(negedge clk) begin
    if (cs_i && !rd_n) begin
      if (rd_exp.size() == 0) begin
        check_int("rd_unexpected", 1, 0);
      end else begin
        logic [7:0] e;
        string nm;
        e  = rd_exp.pop_front();
        nm = rd_name.pop_front();
        check8(nm, data_o, e);
      end
    end else begin
      check8("data_o_idle", data_o, 8'h00);
    end
  end

  // TX monitor: decode frames from tx_o at mid-bit points.
  initial begin
    logic       prev;
    logic [7:0] b;
    logic       stopb;
    int         s;
    txe_t       e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !tx_o) begin
        s = cyc;
        repeat (D + D / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = tx_o;
          repeat (D) @(negedge clk);
        end
        stopb = tx_o;
        if (tx_abort) begin
          tx_abort = 1'b0;
          if (tx_exp.size() != 0) void'(tx_exp.pop_front());
        end else if (tx_exp.size() == 0) begin
          check_int("tx_unexpected_frame", s, -1);
        end else begin
          e = tx_exp.pop_front();
          check8("tx_data", b, e.b);
          check_int("tx_start_cycle", s, e.start);
          check8("tx_stop", {7'b0, stopb}, 8'h01);
        end
        prev = stopb;
      end else begin
        prev = tx_o;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w, s1, w2;
    @(posedge clk); #1;
    idle(2);
    // Reset state
    check8("rst_tx_o", {7'b0, tx_o}, 8'h01);
    cpu_read(1'b1, 1, "rst_status");
    cpu_read(1'b0, 1, "rst_data");
    rst_n_i = 1'b1;
    idle(2);

    // Single byte: tx_ready drop, busy window edges
    w = cyc;
    cpu_write(1'b0, 8'h55, 1);
    cpu_read(1'b1, 1, "tx1_status_loaded");
    cpu_read(1'b1, 1, "tx1_status_busy");
    wait_until(w + 2 + 10 * D - 2);
    cpu_read(1'b1, 4, "tx1_busy_end");
    wait_until(w + 2 + 11 * D);

    // Back-to-back frames, third write dropped
    w = cyc;
    s1 = w + 2;
    cpu_write(1'b0, 8'hA5, 2);
    wait_until(s1 + 3 * D);
    w2 = cyc;
    cpu_write(1'b0, 8'h3C, 2);
    cpu_write(1'b0, 8'h77, 2);
    cpu_write(1'b1, 8'hEE, 1);
    wait_until(s1 + 10 * D - 2);
    cpu_read(1'b1, 4, "b2b_boundary");
    wait_until(s1 + 21 * D);

    // RX single byte
    send_frame(8'hC3, 1'b1);
    cpu_read(1'b1, 1, "rx_status_avail");
    cpu_read(1'b0, 1, "rx_data");
    cpu_read(1'b1, 1, "rx_status_empty");
    cpu_read(1'b0, 1, "rx_data_empty");

    // Short low glitch is a false start
    rx_i = 1'b0;
    idle(D / 4);
    rx_i = 1'b1;
    idle(12 * D);
    cpu_read(1'b1, 1, "glitch_status");

    // Frame error
    send_frame(8'h5A, 1'b0);
    cpu_read(1'b1, 1, "ferr_status");
    cpu_read(1'b1, 1, "ferr_cleared");
    cpu_read(1'b0, 1, "ferr_data");

    // Overrun: one more frame than the storage holds
    for (int i = 0; i < CAP + 1; i++) send_frame(8'($urandom), 1'b1);
    cpu_read(1'b1, 1, "ovr_status");
    for (int i = 0; i < CAP + 1; i++) cpu_read(1'b0, 1, "ovr_data");
    cpu_read(1'b1, 1, "ovr_status_after");

    // Randomised mix
    repeat (30) begin
      case ($urandom_range(0, 4))
        0, 1: send_frame(8'($urandom), ($urandom_range(0, 7) != 0));
        2: cpu_read(1'b0, 1, "rand_data");
        3: cpu_read(1'b1, $urandom_range(1, 3), "rand_status");
        default: cpu_write(1'($urandom_range(0, 3) == 0), 8'($urandom), $urandom_range(1, 3));
      endcase
      idle($urandom_range(0, 40));
    end
    wait_until(last_start + 10 * D + 4);
    while (m_rx.size() != 0) cpu_read(1'b0, 1, "drain_data");
    cpu_read(1'b1, 1, "drain_status");

    // Reset in the middle of a TX frame
    w = cyc;
    cpu_write(1'b0, 8'hE7, 1);
    wait_until(w + 2 + 3 * D);
    tx_abort = 1'b1;
    rst_n_i = 1'b0;
    #1;
    check8("rst_mid_tx_o", {7'b0, tx_o}, 8'h01);
    model_reset();
    cpu_read(1'b1, 1, "rst_mid_status");
    rst_n_i = 1'b1;
    idle(12 * D);
    w = cyc;
    cpu_write(1'b0, 8'h81, 1);
    wait_until(w + 2 + 11 * D);

    check_int("tx_exp_left", tx_exp.size(), 0);
    check_int("rd_exp_left", rd_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
